// File: rtl/vend_credit_fsm.sv
// vend_credit_fsm: coin-credit vending controller with change and refund payout
//
// Accumulates coin credit. When the credit reaches PRICE it vends one product,
// then returns any surplus as one-unit change pulses. Cancel or an inactivity
// timeout in COLLECT refunds the whole credit the same way.
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   synchronous active-low reset; discards credit with no payout
//   coin_valid in   coin strobe, one cycle per coin
//   coin_val   in   coin value in units (0 = no coin)
//   cancel     in   customer cancel level, honoured in COLLECT only
//   vend       out  product dispense, one cycle per sale
//   chg_pulse  out  one unit paid out (change or refund)
//   refund     out  qualifies chg_pulse as a refund
//   coin_rej   out  combinational: nonzero coin offered while paying out
//   timeout    out  combinational: COLLECT->REFUND due to inactivity this cycle
//   busy       out  controller not idle
//   credit     out  current credit
module vend_credit_fsm #(
    parameter int COIN_W   = 2,
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int TIME_OUT = 20,
    parameter int TMR_W    = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_val,
    input  logic                cancel,
    output logic                vend,
    output logic                chg_pulse,
    output logic                refund,
    output logic                coin_rej,
    output logic                timeout,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);
    // The credit register must hold PRICE-1 plus the largest coin without wrapping.
    if (PRICE < 1 || PRICE > 2**CREDIT_W - 1 ||
        PRICE - 1 + 2**COIN_W - 1 > 2**CREDIT_W - 1 ||
        TIME_OUT < 1 || TIME_OUT > 2**TMR_W - 1 || CREDIT_W < COIN_W) begin : g_param_err
        $error("vend_credit_fsm: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE, S_REFUND} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, sum;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                vend_q, chg_q, refund_q, busy_q;
    logic                accepting, accept, cancel_c, buy, tmo;

    always_comb begin
        accepting = state_q == S_IDLE || state_q == S_COLLECT;
        accept    = coin_valid && coin_val != '0 && accepting;
        cancel_c  = state_q == S_COLLECT && cancel;
        sum       = credit_q + (accept ? CREDIT_W'(coin_val) : '0);
        // A coin arriving with cancel is credited and then refunded, never sold.
        buy       = accept && !cancel_c && sum >= CREDIT_W'(PRICE);
        tmo       = state_q == S_COLLECT && !cancel && !accept &&
                    timer_q == TMR_W'(TIME_OUT - 1);
        state_d   = state_q;
        credit_d  = credit_q;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                credit_d = buy ? sum - CREDIT_W'(PRICE) : sum;
                state_d  = cancel_c ? S_REFUND :
                           buy      ? S_VEND :
                           accept   ? S_COLLECT :
                           tmo      ? S_REFUND : state_q;
            end
            S_VEND:             state_d = credit_q == '0 ? S_IDLE : S_CHANGE;
            S_CHANGE, S_REFUND: begin
                credit_d = credit_q - CREDIT_W'(credit_q != '0);
                state_d  = credit_q <= CREDIT_W'(1) ? S_IDLE : state_q;
            end
            default:            state_d = S_IDLE;
        endcase
        // Timer restarts on entry to COLLECT and on every accepted coin.
        timer_d = (state_q == S_COLLECT && state_d == S_COLLECT && !accept) ?
                  timer_q + TMR_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            timer_q  <= '0;
            vend_q   <= 1'b0;
            chg_q    <= 1'b0;
            refund_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            vend_q   <= state_d == S_VEND;
            chg_q    <= state_d == S_CHANGE || state_d == S_REFUND;
            refund_q <= state_d == S_REFUND;
            busy_q   <= state_d != S_IDLE;
        end
    end

    assign vend      = vend_q;
    assign chg_pulse = chg_q;
    assign refund    = refund_q;
    assign busy      = busy_q;
    assign credit    = credit_q;
    assign coin_rej  = coin_valid && coin_val != '0 && !accepting;
    assign timeout   = tmo;
endmodule

// File: tb/tb_vend_credit_fsm.sv
// tb_vend_credit_fsm: directed and random checks of vend_credit_fsm against a payout-queue model
module tb_vend_credit_fsm;
    localparam int PRICE = 3;
    localparam int TO    = 20;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_val = '0;
    logic       cancel = 1'b0;
    logic       vend, chg_pulse, refund, coin_rej, timeout, busy;
    logic [3:0] credit;

    vend_credit_fsm dut (
        .clk(clk), .rstn(rstn), .coin_valid(coin_valid), .coin_val(coin_val),
        .cancel(cancel), .vend(vend), .chg_pulse(chg_pulse), .refund(refund),
        .coin_rej(coin_rej), .timeout(timeout), .busy(busy), .credit(credit)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int vends    = 0;

    // Model: credit held, pending output events (1=vend, 2=change unit, 3=refund unit),
    // and idle cycles spent collecting. Idle when no events and credit is zero.
    int m_credit = 0;
    int m_idle   = 0;
    int q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit cv, input int val, input bit cc, input bit rn, input bit chk);
        int  front, sum;
        bit  acc;
        @(negedge clk);
        coin_valid = cv;
        coin_val   = 2'(val);
        cancel     = cc;
        rstn       = rn;
        #1;
        front = q.size() != 0 ? q[0] : 0;
        acc   = cv && val != 0 && q.size() == 0;
        if (chk) begin
            check("vend",      32'(vend),      32'(front == 1));
            check("chg_pulse", 32'(chg_pulse), 32'(front >= 2));
            check("refund",    32'(refund),    32'(front == 3));
            check("coin_rej",  32'(coin_rej),  32'(cv && val != 0 && q.size() != 0));
            check("timeout",   32'(timeout),
                  32'(q.size() == 0 && m_credit > 0 && !cc && !acc && m_idle == TO - 1));
            check("busy",      32'(busy),      32'(q.size() != 0 || m_credit > 0));
            check("credit",    32'(credit),    32'(m_credit));
            pulses += int'(chg_pulse === 1'b1);
            vends  += int'(vend === 1'b1);
        end
        if (!rn) begin
            q.delete();
            m_credit = 0;
            m_idle   = 0;
        end else if (q.size() != 0) begin
            if (q.pop_front() >= 2) m_credit--;
        end else begin
            sum = m_credit + (acc ? val : 0);
            if (m_credit > 0 && cc) begin
                m_credit = sum;
                repeat (sum) q.push_back(3);
            end else if (acc) begin
                m_idle = 0;
                if (sum >= PRICE) begin
                    m_credit = sum - PRICE;
                    q.push_back(1);
                    repeat (m_credit) q.push_back(2);
                end else m_credit = sum;
            end else if (m_credit > 0) begin
                if (m_idle == TO - 1) repeat (m_credit) q.push_back(3);
                else m_idle++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 1, 1);
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(2);
        // 1: coin 1 then coin 2 -> one vend, no change
        pulses = 0; vends = 0;
        step(1, 1, 0, 1, 1); step(1, 2, 0, 1, 1); idle(3);
        check("t1_vends", 32'(vends), 32'd1);
        check("t1_pulses", 32'(pulses), 32'd0);
        // 2: coin 2 then coin 2 -> vend then one change unit
        pulses = 0; vends = 0;
        step(1, 2, 0, 1, 1); step(1, 2, 0, 1, 1); idle(4);
        check("t2_vends", 32'(vends), 32'd1);
        check("t2_pulses", 32'(pulses), 32'd1);
        // 3: coin 1 then inactivity -> timeout refund of one unit
        pulses = 0; vends = 0;
        step(1, 1, 0, 1, 1); idle(24);
        check("t3_pulses", 32'(pulses), 32'd1);
        check("t3_vends", 32'(vends), 32'd0);
        // 4: coin 2, cancel with coin 3 -> five refund units, coin 1 rejected mid-refund
        pulses = 0;
        step(1, 2, 0, 1, 1); step(1, 3, 1, 1, 1);
        step(1, 1, 0, 1, 1); step(1, 1, 0, 1, 1); idle(6);
        check("t4_pulses", 32'(pulses), 32'd5);
        // 5: exact coin 3, second coin 3 during VEND rejected
        pulses = 0; vends = 0;
        step(1, 3, 0, 1, 1); step(1, 3, 0, 1, 1); idle(3);
        check("t5_vends", 32'(vends), 32'd1);
        check("t5_pulses", 32'(pulses), 32'd0);
        // 6: reset in CHANGE with credit 2 -> no further pulses
        pulses = 0;
        step(1, 2, 0, 1, 1); step(1, 3, 0, 1, 1); idle(1);
        step(0, 0, 0, 0, 1); idle(4);
        check("t6_pulses", 32'(pulses), 32'd1);
        // random traffic, alternating sparse and dense coin phases
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(99) < ((b % 2 != 0) ? 40 : 3), int'($urandom_range(3)),
                     $urandom_range(99) < 2, $urandom_range(299) != 0, 1);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
